instr_mem_loader: RTL and testbench

- Write-side counterpart of the byte-addressed, big-endian instruction memory.
- Accepts a byte stream over a valid/ready handshake, assembles bytes into 32-bit words, and issues one-cycle word writes into the instruction store.
- Holds the processor in stall while a program image is loading.
- Sits between the test/boot byte source and the instruction memory write port.

---
 rtl/instr_mem_loader.sv | 111 +++++++++++
 tb/tb_instr_mem_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the big-endian instruction store: packs bytes into 32-bit words.
// Latency: a byte transfer reaches the word write strobe one cycle later.
// Backpressure: byte_ready is high for the whole LOAD state, so a continuous stream never stalls.
//
// Ports:
//   clk, rst           system clock (rising edge) and asynchronous active-high reset
//   start              one-cycle pulse that opens a load session at address 0
//   byte_valid/ready   byte handshake; byte_data in ascending address order;
//                      byte_last marks the final byte of the image
//   wr_en/addr/data    one-cycle word write into the instruction store
//                      (lowest address in the MSB lane)
//   cpu_hold           processor stall request while the image is being loaded
//   done               session finished
//   error              sticky flag: the image was larger than MEM_BYTES
//   byte_count         number of bytes stored in this session
module instr_mem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] byte_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] byte_ptr;
  logic [31:0]       asm_word;
  logic              xfer;
  logic              room;
  logic [31:0]       merged;

  assign xfer = byte_valid && (state == LOAD);
  assign room = byte_ptr < LIMIT;

  // Lane 0 (lowest address) lands in bits [31:24]: shift by (3 - lane) * 8.
  assign merged = asm_word | ({24'd0, byte_data} << {~byte_ptr[1:0], 3'b000});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (xfer && byte_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // The stall is released once the flush write of the final word has gone out.
  assign byte_ready = (state == LOAD);
  assign done       = (state == DONE);
  assign cpu_hold   = (state == LOAD) || ((state == DONE) && wr_en);
  assign byte_count = byte_ptr;  // pointer stops at LIMIT, so the count saturates with it

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_ptr <= '0;
      asm_word <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if ((state != LOAD) && start) begin
        byte_ptr <= '0;
        asm_word <= '0;
        error    <= 1'b0;
      end else if (xfer) begin
        if (room) begin
          byte_ptr <= byte_ptr + ADDR_W'(1);
          if ((byte_ptr[1:0] == 2'd3) || byte_last) begin
            // Emit the word and clear the assembly register on the same edge,
            // so the next byte can be accepted without a bubble.
            wr_en    <= 1'b1;
            wr_addr  <= {byte_ptr[ADDR_W-1:2], 2'b00};
            wr_data  <= merged;
            asm_word <= '0;
          end else begin
            asm_word <= merged;
          end
        end else begin
          // Store is full: the byte is dropped. LIMIT is a multiple of 4, so no
          // partial word can be pending here.
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam int MEMB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [31:0] byte_count;

  instr_mem_loader #(.MEM_BYTES(MEMB), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .error(error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: session mode (0 idle, 1 loading, 2 finished), the image
  // stored so far, and the write expected in the current cycle.
  int          m_mode = 0;
  logic [7:0]  img[$];
  logic        m_err = 1'b0;
  logic        m_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".byte_ready"}, 32'(byte_ready), 32'(m_mode == 1));
    chk({ctx, ".wr_en"},      32'(wr_en),      32'(m_wr));
    if (m_wr) begin
      chk({ctx, ".wr_addr"}, wr_addr, m_addr);
      chk({ctx, ".wr_data"}, wr_data, m_data);
    end
    chk({ctx, ".cpu_hold"},   32'(cpu_hold),   32'((m_mode == 1) || (m_mode == 2 && m_wr)));
    chk({ctx, ".done"},       32'(done),       32'(m_mode == 2));
    chk({ctx, ".error"},      32'(error),      32'(m_err));
    chk({ctx, ".byte_count"}, byte_count,      32'(img.size()));
  endtask

  // Drive one cycle of inputs, advance the model over the coming edge, then check.
  task automatic step(input logic s, input logic v, input logic [7:0] d, input logic l);
    int a;
    start      = s;
    byte_valid = v;
    byte_data  = d;
    byte_last  = l;
    m_wr = 1'b0;
    if (m_mode == 1) begin
      if (v) begin
        if (img.size() < MEMB) begin
          img.push_back(d);
          if ((img.size() % 4 == 0) || l) begin
            a      = ((img.size() - 1) / 4) * 4;
            m_wr   = 1'b1;
            m_addr = 32'(a);
            m_data = '0;
            for (int k = 0; k < 4; k++)
              if (a + k < img.size()) m_data |= 32'(img[a + k]) << (8 * (3 - k));
          end
        end else begin
          m_err = 1'b1;
        end
        if (l) m_mode = 2;
      end
    end else if (s) begin
      m_mode = 1;
      img.delete();
      m_err = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic load(input int n, input logic [7:0] base);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, base + 8'(i), i == n - 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0);  // valid while not ready: must be ignored
  endtask

  task automatic apply_reset_mid_cycle();
    #2;
    rst = 1'b1;
    #1;
    m_mode = 0; img.delete(); m_err = 1'b0; m_wr = 1'b0;
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    int i;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 8'h55, 1'b1);  // idle: no transfer even with valid+last

    // Two full words, back to back.
    load(8, 8'h00);
    // Partial final word is zero-padded.
    load(6, 8'hA0);
    // Overflow: 10 bytes into an 8-byte store.
    load(10, 8'h10);

    // Gapped source over 4 bytes, then a last byte.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 8'hC0 + 8'(k), 1'b0);
      step(1'b0, 1'b0, 8'hFF, 1'b0);
      step(1'b0, 1'b0, 8'hFF, 1'b1);
    end
    step(1'b0, 1'b1, 8'hC4, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset after 3 bytes, then a clean session.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h90 + 8'(k), 1'b0);
    apply_reset_mid_cycle();
    load(4, 8'h50);

    // Start pulse in the middle of a load is ignored.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h31, 1'b0);
    step(1'b0, 1'b1, 8'h32, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    step(1'b0, 1'b1, 8'h34, 1'b0);
    step(1'b0, 1'b1, 8'h35, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Randomised sessions with gaps, stray starts and overflow.
    repeat (30) begin
      step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      len = $urandom_range(1, 12);
      i = 0;
      while (i < len) begin
        if ($urandom_range(0, 3) == 0) begin
          step(1'($urandom_range(0, 4) == 0), 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
        end else begin
          step(1'($urandom_range(0, 5) == 0), 1'b1, 8'($urandom), i == len - 1);
          i++;
        end
      end
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
